id_ex_stage: RTL and testbench

//  Decode->Execute pipeline register of the pipelined MIPS core. Captures the decoder's control word
//  (rfwrite/memtorf/memwrite/alusrc/rfdst/branch/jump/alucontrol) plus operands and register addresses.

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register for the pipelined MIPS core, with load-use hazard detection.
// Latency: 1 cycle D->E; lwstall_o is combinational from registered E state and the current D inputs.
// Backpressure: hold_i freezes every E field; flush_i or a load-use stall loads a bubble instead of D.
//
// Ports:
//   clk_i, rst_n_i       single rising-edge clock; synchronous active-low reset
//   *_d_i                decoder control word, operands, PC+4 and register fields of the D instruction
//   hold_i, flush_i      downstream stall and branch/jump redirect
//   *_e_o                registered copy of every *_d_i (valid_e_o included)
//   lwstall_o            load-use stall request to the PC and IF/ID registers
//   bubble_cnt_o         saturating count of inserted bubbles (only when IDEX_PERF_CNT_EN is defined)
//
// Build option: define IDEX_PERF_CNT_EN to add the bubble counter and its CNT_W parameter.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
`ifdef IDEX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_d_i,
  input  logic             rfwrite_d_i,
  input  logic             memtorf_d_i,
  input  logic             memwrite_d_i,
  input  logic             alusrc_d_i,
  input  logic             rfdst_d_i,
  input  logic             branch_d_i,
  input  logic             jump_d_i,
  input  logic [2:0]       alucontrol_d_i,
  input  logic [WIDTH-1:0] rd1_d_i,
  input  logic [WIDTH-1:0] rd2_d_i,
  input  logic [WIDTH-1:0] signimm_d_i,
  input  logic [WIDTH-1:0] pcplus4_d_i,
  input  logic [RA_W-1:0]  rs_d_i,
  input  logic [RA_W-1:0]  rt_d_i,
  input  logic [RA_W-1:0]  rd_d_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             valid_e_o,
  output logic             rfwrite_e_o,
  output logic             memtorf_e_o,
  output logic             memwrite_e_o,
  output logic             alusrc_e_o,
  output logic             rfdst_e_o,
  output logic             branch_e_o,
  output logic             jump_e_o,
  output logic [2:0]       alucontrol_e_o,
  output logic [WIDTH-1:0] rd1_e_o,
  output logic [WIDTH-1:0] rd2_e_o,
  output logic [WIDTH-1:0] signimm_e_o,
  output logic [WIDTH-1:0] pcplus4_e_o,
  output logic [RA_W-1:0]  rs_e_o,
  output logic [RA_W-1:0]  rt_e_o,
  output logic [RA_W-1:0]  rd_e_o,
  output logic             lwstall_o
`ifdef IDEX_PERF_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt_o
`else
  // no bubble counter port in this build
`endif
);

  logic bubble;

  // A load in E whose destination ($rt) is read by the D instruction. $0 is never a real
  // dependency, and an invalid D slot cannot consume anything.
  assign lwstall_o = valid_e_o & memtorf_e_o & valid_d_i & (rt_e_o != '0) &
                     ((rt_e_o == rs_d_i) | (rt_e_o == rt_d_i));

  // Flush and load-use stall collapse into one bubble.
  assign bubble = flush_i | lwstall_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || (!hold_i && bubble)) begin
      valid_e_o      <= 1'b0;
      rfwrite_e_o    <= 1'b0;
      memtorf_e_o    <= 1'b0;
      memwrite_e_o   <= 1'b0;
      alusrc_e_o     <= 1'b0;
      rfdst_e_o      <= 1'b0;
      branch_e_o     <= 1'b0;
      jump_e_o       <= 1'b0;
      alucontrol_e_o <= '0;
      rd1_e_o        <= '0;
      rd2_e_o        <= '0;
      signimm_e_o    <= '0;
      pcplus4_e_o    <= '0;
      rs_e_o         <= '0;
      rt_e_o         <= '0;
      rd_e_o         <= '0;
    end else if (!hold_i) begin
      valid_e_o      <= valid_d_i;
      // Architectural side effects are masked so an invalid slot can never write state.
      rfwrite_e_o    <= rfwrite_d_i & valid_d_i;
      memwrite_e_o   <= memwrite_d_i & valid_d_i;
      memtorf_e_o    <= memtorf_d_i;
      alusrc_e_o     <= alusrc_d_i;
      rfdst_e_o      <= rfdst_d_i;
      branch_e_o     <= branch_d_i;
      jump_e_o       <= jump_d_i;
      alucontrol_e_o <= alucontrol_d_i;
      rd1_e_o        <= rd1_d_i;
      rd2_e_o        <= rd2_d_i;
      signimm_e_o    <= signimm_d_i;
      pcplus4_e_o    <= pcplus4_d_i;
      rs_e_o         <= rs_d_i;
      rt_e_o         <= rt_d_i;
      rd_e_o         <= rd_d_i;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Saturating: once all ones it stays there until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= '0;
    end else if (!hold_i && bubble && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of D-stage vectors with expected lwstall_o and
// expected E contents, plus hand-written reset and bubble-counter sequences.
// Build with IDEX_PERF_CNT_EN defined to also exercise the counter (CNT_W=2).
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        rfwrite;
    logic        memtorf;
    logic        memwrite;
    logic        alusrc;
    logic        rfdst;
    logic        branch;
    logic        jump;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  typedef struct {
    stage_t d;
    logic   hold;
    logic   flush;
    logic   stall;
    stage_t e;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   hold, flush;
  stage_t d_in;
  stage_t e_got;
  logic   lwstall;
  int     checks = 0;
  int     errors = 0;

`ifdef IDEX_PERF_CNT_EN
  localparam int CW = 2;
  logic [CW-1:0] cnt;
  int            exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(
    .WIDTH(32), .RA_W(5)
`ifdef IDEX_PERF_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_d_i(d_in.valid), .rfwrite_d_i(d_in.rfwrite), .memtorf_d_i(d_in.memtorf),
    .memwrite_d_i(d_in.memwrite), .alusrc_d_i(d_in.alusrc), .rfdst_d_i(d_in.rfdst),
    .branch_d_i(d_in.branch), .jump_d_i(d_in.jump), .alucontrol_d_i(d_in.alu),
    .rd1_d_i(d_in.rd1), .rd2_d_i(d_in.rd2), .signimm_d_i(d_in.imm), .pcplus4_d_i(d_in.pc4),
    .rs_d_i(d_in.rs), .rt_d_i(d_in.rt), .rd_d_i(d_in.rd),
    .hold_i(hold), .flush_i(flush),
    .valid_e_o(e_got.valid), .rfwrite_e_o(e_got.rfwrite), .memtorf_e_o(e_got.memtorf),
    .memwrite_e_o(e_got.memwrite), .alusrc_e_o(e_got.alusrc), .rfdst_e_o(e_got.rfdst),
    .branch_e_o(e_got.branch), .jump_e_o(e_got.jump), .alucontrol_e_o(e_got.alu),
    .rd1_e_o(e_got.rd1), .rd2_e_o(e_got.rd2), .signimm_e_o(e_got.imm), .pcplus4_e_o(e_got.pc4),
    .rs_e_o(e_got.rs), .rt_e_o(e_got.rt), .rd_e_o(e_got.rd),
    .lwstall_o(lwstall)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_cnt_o(cnt)
`endif
  );

  function automatic stage_t mk(input logic v, rfw, m2r, mw, asrc, rdst, br, jmp,
                                input logic [2:0] alu, input logic [31:0] rd1, rd2, imm, pc4,
                                input logic [4:0] rs, rt, rd);
    stage_t s;
    s = '{v, rfw, m2r, mw, asrc, rdst, br, jmp, alu, rd1, rd2, imm, pc4, rs, rt, rd};
    return s;
  endfunction

  task automatic chk(input string name, input int idx, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  // Samples E after an edge; the counter model advances on the same edge.
  task automatic after_edge(input string name, input int idx, input stage_t exp_e, input logic cnt_step);
    @(posedge clk);
    #1;
    chk(name, idx, 160'(e_got), 160'(exp_e));
`ifdef IDEX_PERF_CNT_EN
    if (!rst_n) exp_cnt = 0;
    else if (cnt_step && exp_cnt < (1 << CW) - 1) exp_cnt++;
    chk({name, "_cnt"}, idx, 160'(cnt), 160'(exp_cnt));
`else
    if (cnt_step) begin end
`endif
  endtask

  vec_t vecs[26];
  stage_t bub, add1, lw4, add_h, lw0, add0, inv_d, inv_e, sw4, lw6, lw7, lw8, addf, addg, br;

  initial begin
    bub   = '0;
    //          v rfw m2r mw asrc rdst br jmp alu     rd1 rd2 imm pc4       rs rt rd
    add1  = mk(1, 1, 0, 0, 0, 1, 0, 0, 3'b010, 5,  7,  0,  32'h100, 1, 2, 3);
    lw4   = mk(1, 1, 1, 0, 1, 0, 0, 0, 3'b010, 8,  0,  4,  32'h104, 1, 4, 0);
    add_h = mk(1, 1, 0, 0, 0, 1, 0, 0, 3'b010, 9,  11, 0,  32'h108, 4, 2, 5);
    lw0   = mk(1, 1, 1, 0, 1, 0, 0, 0, 3'b010, 1,  0,  8,  32'h10c, 1, 0, 0);
    add0  = mk(1, 1, 0, 0, 0, 1, 0, 0, 3'b010, 2,  3,  0,  32'h110, 0, 0, 6);
    inv_d = mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b110, 7,  8,  9,  32'h114, 3, 4, 7);
    inv_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b110, 7,  8,  9,  32'h114, 3, 4, 7);
    sw4   = mk(1, 0, 0, 1, 1, 0, 0, 0, 3'b010, 12, 13, 16, 32'h118, 2, 4, 0);
    lw6   = mk(1, 1, 1, 0, 1, 0, 0, 0, 3'b010, 20, 0,  0,  32'h11c, 1, 6, 0);
    lw7   = mk(1, 1, 1, 0, 1, 0, 0, 0, 3'b010, 21, 0,  4,  32'h120, 6, 7, 0);
    lw8   = mk(1, 1, 1, 0, 1, 0, 0, 0, 3'b010, 22, 0,  8,  32'h124, 7, 8, 0);
    addf  = mk(1, 1, 0, 0, 0, 1, 0, 0, 3'b010, 1,  2,  0,  32'h128, 8, 1, 9);
    addg  = mk(1, 1, 0, 0, 0, 1, 0, 0, 3'b010, 3,  4,  0,  32'h12c, 1, 2, 10);
    br    = mk(1, 0, 0, 0, 0, 0, 1, 0, 3'b110, 5,  5,  4,  32'h130, 1, 1, 0);

    //           D      hold  flush stall  expected E
    vecs[0]  = '{add1,  1'b0, 1'b0, 1'b0, add1};   // plain add
    vecs[1]  = '{lw4,   1'b0, 1'b0, 1'b0, lw4};
    vecs[2]  = '{add_h, 1'b0, 1'b0, 1'b1, bub};    // rs=4 depends on lw $4
    vecs[3]  = '{add_h, 1'b0, 1'b0, 1'b0, add_h};  // one bubble only
    vecs[4]  = '{lw0,   1'b0, 1'b0, 1'b0, lw0};
    vecs[5]  = '{add0,  1'b0, 1'b0, 1'b0, add0};   // $0 never stalls
    vecs[6]  = '{lw4,   1'b0, 1'b0, 1'b0, lw4};
    vecs[7]  = '{inv_d, 1'b0, 1'b0, 1'b0, inv_e};  // invalid D: no stall, writes masked
    vecs[8]  = '{lw4,   1'b0, 1'b0, 1'b0, lw4};
    vecs[9]  = '{sw4,   1'b0, 1'b0, 1'b1, bub};    // match on rt
    vecs[10] = '{sw4,   1'b0, 1'b0, 1'b0, sw4};
    vecs[11] = '{lw6,   1'b0, 1'b0, 1'b0, lw6};
    vecs[12] = '{lw7,   1'b0, 1'b0, 1'b1, bub};    // load chain, each stalls once
    vecs[13] = '{lw7,   1'b0, 1'b0, 1'b0, lw7};
    vecs[14] = '{lw8,   1'b0, 1'b0, 1'b1, bub};
    vecs[15] = '{lw8,   1'b0, 1'b0, 1'b0, lw8};
    vecs[16] = '{addf,  1'b0, 1'b1, 1'b1, bub};    // flush and stall together
    vecs[17] = '{addg,  1'b0, 1'b1, 1'b0, bub};    // flush alone
    vecs[18] = '{addg,  1'b0, 1'b0, 1'b0, addg};
    vecs[19] = '{br,    1'b0, 1'b0, 1'b0, br};
    vecs[20] = '{lw4,   1'b0, 1'b0, 1'b0, lw4};
    vecs[21] = '{add_h, 1'b1, 1'b1, 1'b1, lw4};    // hold wins over flush and stall
    vecs[22] = '{sw4,   1'b1, 1'b1, 1'b1, lw4};
    vecs[23] = '{add1,  1'b1, 1'b1, 1'b0, lw4};
    vecs[24] = '{add1,  1'b0, 1'b1, 1'b0, bub};    // release with flush still high
    vecs[25] = '{add1,  1'b0, 1'b0, 1'b0, add1};

    // Reset with every input high, including hold and flush.
    @(negedge clk);
    rst_n = 1'b0; d_in = '1; hold = 1'b1; flush = 1'b1;
    after_edge("reset_e", 0, bub, 1'b0);
    chk("reset_stall", 0, 160'(lwstall), 160'(0));

    // Five counted flush edges with a held edge in between.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = 1'b1; d_in = add1; flush = 1'b1; hold = (i == 2);
      after_edge("flush_seq", i, bub, (i != 2));
    end

    // Mid-flight reset clears the counter and E.
    @(negedge clk);
    d_in = add1; hold = 1'b0; flush = 1'b0;
    after_edge("load_pre_rst", 0, add1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b1;
    after_edge("reset2_e", 0, bub, 1'b0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst_n = 1'b1; d_in = vecs[i].d; hold = vecs[i].hold; flush = vecs[i].flush;
      #1;
      chk("lwstall", i, 160'(lwstall), 160'(vecs[i].stall));
      after_edge("e_state", i, vecs[i].e, !vecs[i].hold && (vecs[i].flush || vecs[i].stall));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
